// File: rtl/shift_arbiter_pkg.sv
// Shared encodings for the shift arbiter: shift selects and response-holding states.
package shift_arbiter_pkg;

  typedef enum logic [1:0] {
    SH_SRL  = 2'b00,
    SH_SLL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_PASS = 2'b11
  } alusel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/rr_select.sv
// Round-robin priority select: first asserted request scanning upward from ptr, wrapping at NREQ.
module rr_select #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_idx
);

  // Padded so any IDW-bit index is in range; indices >= NREQ read as zero and never win.
  logic [2**IDW-1:0] req_pad;
  logic [IDW-1:0]    idx;

  always_comb begin
    req_pad           = '0;
    req_pad[NREQ-1:0] = req;
    grant_valid       = 1'b0;
    grant_idx         = '0;
    idx               = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (!grant_valid && req_pad[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/shifter.sv
// Combinational 32-bit shifter: SRL, SLL, SRA or pass-through.
module shifter
  import shift_arbiter_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  input  alusel_e     alusel_i,
  output logic [31:0] r_o
);

  always_comb begin
    r_o = a_i;
    unique case (alusel_i)
      SH_SRL:  r_o = a_i >> shamt_i;
      SH_SLL:  r_o = a_i << shamt_i;
      SH_SRA:  r_o = $unsigned($signed(a_i) >>> shamt_i);
      SH_PASS: r_o = a_i;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one shifter between NREQ valid/ready requesters; registered, id-tagged response.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [5*NREQ-1:0]  req_shamt,
  input  logic [2*NREQ-1:0]  req_alusel,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [31:0]        resp_r
);

  state_e         state_q, state_d;
  logic [31:0]    r_q, r_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           grant_valid;
  logic [IDW-1:0] grant_idx;
  logic           can_accept;
  logic           accept;
  logic [31:0]    sel_a;
  logic [4:0]     sel_shamt;
  alusel_e        sel_alusel;
  logic [31:0]    sh_r;

  rr_select #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_rr_select (
    .req        (req_valid),
    .ptr        (ptr_q),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    sel_a      = '0;
    sel_shamt  = '0;
    sel_alusel = SH_SRL;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a      = req_a[32*i +: 32];
        sel_shamt  = req_shamt[5*i +: 5];
        sel_alusel = alusel_e'(req_alusel[2*i +: 2]);
      end
    end
  end

  shifter u_shifter (
    .a_i     (sel_a),
    .shamt_i (sel_shamt),
    .alusel_i(sel_alusel),
    .r_o     (sh_r)
  );

  assign resp_valid = (state_q == ST_HOLD);
  assign resp_id    = id_q;
  assign resp_r     = r_q;

  // Consuming the held result frees the register for a new load at the same edge.
  assign can_accept = (state_q == ST_IDLE) | (resp_ready & resp_valid);
  assign accept     = grant_valid & can_accept;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = rst & accept & (grant_idx == IDW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d = ST_HOLD;
      r_d     = sh_r;
      id_d    = grant_idx;
      ptr_d   = IDW'((32'(grant_idx) + 32'd1) % NREQ);
    end else if (state_q == ST_HOLD && resp_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational Shifter instance between NREQ requesters, e.g. the EX-stage ALU path and a load/store byte-alignment unit.
- Each requester uses a valid/ready handshake. A round-robin grant picks one request per cycle.
- The shifted result is registered and returned on a single response channel, tagged with the requester index.
- Sits beside the ALU in EX. It is the only path by which non-ALU blocks reach the shifter.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 2, width of the response id field; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  32*NREQ  flattened operand; requester i uses bits [32i+31:32i].
- req_shamt  in  5*NREQ  flattened shift amount.
- req_alusel  in  2*NREQ  flattened shift select: 00 SRL, 01 SLL, 10 SRA, 11 pass-through.
- resp_valid  out  1  registered result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_r  out  32  shifted result.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; resp_valid=0, resp_id=0, resp_r=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is all zeros while rst=0.
- States:
  - IDLE: no result held.
  - HOLD: result register valid, resp_valid=1.
- Accept condition: can_accept = (state==IDLE) | (resp_ready & resp_valid). This gives full throughput of one op per cycle when the consumer never stalls.
- Grant:
  - The winner is the first i with req_valid[i]=1, scanning (rr_ptr, rr_ptr+1, ...) mod NREQ.
  - req_ready[winner] = can_accept. req_ready is combinational from req_valid, state, resp_ready and rr_ptr.
  - A requester must hold valid and operands stable until it sees ready. The arbiter does not depend on this, since it only samples on the accept edge.
- Handshake on accept, when req_valid[w] & req_ready[w] at a rising edge:
  - The Shifter output for a/shamt/alusel of w loads into resp_r.
  - resp_id <= w; state <= HOLD; rr_ptr <= (w+1) mod NREQ.
- Latency: request accepted at edge N gives resp_valid=1 from edge N onward, i.e. visible in the cycle after the accept cycle.
- Response:
  - resp_r and resp_id are stable while resp_valid=1 and resp_ready=0. Backpressure holds the result indefinitely.
  - In HOLD with resp_ready=1 and no winning request: state <= IDLE, resp_valid <= 0. resp_r and resp_id keep their old values; they are don't-care when invalid.
  - In HOLD with resp_ready=1 and a winning request: the result is consumed and the new result loaded at the same edge. resp_valid stays 1.
- Shifter function:
  - SRL: logical right shift.
  - SLL: logical left shift.
  - SRA: arithmetic right shift, sign bit a[31] replicated.
  - 11: r=a.
  - shamt range 0..31; shamt=0 returns a for every alusel.
- rr_ptr advances only on an accept. Idle cycles leave it unchanged.
- A requester index >= NREQ never wins.
- Reset asserted mid-HOLD: the pending result is discarded with no response. After release the first grant goes to requester 0 if it is valid.
- No combinational path from resp_ready to resp_r/resp_id/resp_valid.

Decomposition:
- Shared package/header holds:
  - alusel encodings SH_SRL=2'b00, SH_SLL=2'b01, SH_SRA=2'b10, SH_PASS=2'b11.
  - state encodings ST_IDLE, ST_HOLD.
- Sub-modules:
  - The existing Shifter is instantiated once, driven by a mux on the winner's operands.
  - Round-robin priority select as a sub-module rr_select(NREQ): inputs req, ptr; outputs grant_valid, grant_idx.

Test Plan:
- Single op: rst released; req0 a=32'h8000_0001, shamt=4, alusel=10 (SRA); resp_ready=1. Required: req_ready[0]=1 on the request cycle; next cycle resp_valid=1, resp_id=0, resp_r=32'hF800_0000.
- Fairness: both requesters valid every cycle, resp_ready=1. Grants alternate 0,1,0,1; resp_id sequence 0,1,0,1; one result per cycle. Ops: SLL a=1 shamt=31 gives 32'h8000_0000; SRL a=32'hFFFF_FFFF shamt=31 gives 1.
- Backpressure: hold resp_ready=0 for 5 cycles after an accept. Required: resp_valid stays 1, resp_r/resp_id stable, req_ready=0 throughout. On resp_ready=1 a pending req1 is accepted the same edge and its result appears next cycle.
- Boundaries: shamt=0 with each alusel returns a unchanged. alusel=11 with a=32'hDEAD_BEEF, shamt=7 returns 32'hDEAD_BEEF.
- Reset mid-op: assert rst=0 asynchronously while resp_valid=1. Required: resp_valid=0 immediately, without waiting for a clock edge. After release with both requesters valid, first grant is requester 0.
- Idle pointer hold: grant req1, then 3 idle cycles, then both valid. Required: requester 0 wins (rr_ptr=0 retained).
